dmem_stream_loader: RTL

- Upstream feeder of the dual-port local data memory (dmem) in the FFT accelerator.
- Accepts a stream of complex samples over a valid/ready handshake.
- Drives the dmem port-1 write controls (CSB, WEB, OEB, A, I) with one sample per address, in natural or bit-reversed order.
- Signals frame completion to the FFT sequencer so it can start reading on port 2.

---
 rtl/dmem_stream_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dmem_stream_loader.sv
// Streams complex samples into dmem port 1 in natural or bit-reversed order,
// one registered write per accepted sample, and reports frame completion.
module dmem_stream_loader #(
    parameter int width     = 24,
    parameter int addr_bits = 10,
    parameter int log2_bits = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [log2_bits-1:0] cfg_log2n,
    input  logic                 cfg_bitrev,
    input  logic [addr_bits-1:0] cfg_base,
    input  logic                 in_valid,
    input  logic [width-1:0]     in_data,
    output logic                 in_ready,
    output logic                 CSB1,
    output logic                 WEB1,
    output logic                 OEB1,
    output logic [addr_bits-1:0] A1,
    output logic [width-1:0]     I1,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic [15:0]          frame_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [log2_bits-1:0] MAX_LOG2 = log2_bits'(addr_bits);

    logic [1:0]           state_q,     state_d;
    logic [addr_bits-1:0] cnt_q,       cnt_d;
    logic [log2_bits-1:0] log2n_q,     log2n_d;
    logic                 bitrev_q,    bitrev_d;
    logic [addr_bits-1:0] base_q,      base_d;
    logic                 csb_q,       csb_d;
    logic                 web_q,       web_d;
    logic [addr_bits-1:0] addr_q,      addr_d;
    logic [width-1:0]     data_q,      data_d;
    logic                 done_q,      done_d;
    logic                 cfg_err_q,   cfg_err_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;

    logic                 load_st;
    logic                 accept;
    logic                 cfg_legal;
    logic                 last_sample;
    logic [addr_bits-1:0] last_idx;
    logic [addr_bits-1:0] rev_full;
    logic [log2_bits-1:0] rev_shift;
    logic [addr_bits-1:0] wr_addr;

    assign load_st   = (state_q == ST_LOAD);
    assign accept    = in_valid & load_st;
    assign cfg_legal = (cfg_log2n != '0) && (cfg_log2n <= MAX_LOG2);

    // Index of the final sample: 2**log2n - 1, valid up to log2n == addr_bits.
    assign last_idx    = ~({addr_bits{1'b1}} << log2n_q);
    assign last_sample = (cnt_q == last_idx);

    // Reversing the full-width counter and shifting down leaves exactly the
    // low log2n bits reversed, since the counter never exceeds 2**log2n - 1.
    always_comb begin
        rev_full = '0;
        for (int j = 0; j < addr_bits; j++) begin
            rev_full[j] = cnt_q[addr_bits-1-j];
        end
    end

    assign rev_shift = MAX_LOG2 - log2n_q;
    assign wr_addr   = base_q | (bitrev_q ? (rev_full >> rev_shift) : cnt_q);

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        log2n_d     = log2n_q;
        bitrev_d    = bitrev_q;
        base_d      = base_q;
        csb_d       = 1'b1;
        web_d       = 1'b1;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = 1'b0;
        cfg_err_d   = cfg_err_q;
        frame_cnt_d = frame_cnt_q;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_legal) begin
                            state_d   = ST_LOAD;
                            log2n_d   = cfg_log2n;
                            bitrev_d  = cfg_bitrev;
                            base_d    = cfg_base;
                            cnt_d     = '0;
                            cfg_err_d = 1'b0;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        csb_d  = 1'b0;
                        web_d  = 1'b0;
                        addr_d = wr_addr;
                        data_d = in_data;
                        cnt_d  = cnt_q + addr_bits'(1);
                        if (last_sample) begin
                            state_d     = ST_FLUSH;
                            done_d      = 1'b1;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            log2n_q     <= '0;
            bitrev_q    <= 1'b0;
            base_q      <= '0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            addr_q      <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            log2n_q     <= log2n_d;
            bitrev_q    <= bitrev_d;
            base_q      <= base_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign in_ready  = load_st;
    assign busy      = load_st;
    assign CSB1      = csb_q;
    assign WEB1      = web_q;
    assign OEB1      = 1'b1;
    assign A1        = addr_q;
    assign I1        = data_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule
